mem_burst_tester: RTL
=====================

MEM_BURST_TESTER -- requirements
Module: mem_burst_tester

Interface
REQ-001 Parameter DATA_WIDTH, default 128: burst data width in bits, a multiple of 32.
REQ-002 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 Parameter BURST_LEN, default 16: beats per burst, range 1..256.
REQ-004 Parameter BEGIN_ADDRESS, default 32'h00000000: first byte address tested; burst-aligned.
REQ-005 Parameter END_ADDRESS, default 32'h00ffffff: last byte address tested; (END-BEGIN+1) is a multiple of burst bytes.
REQ-006 Port list (one clock, synchronous active-high reset):
  clk  in  1  clock, the ui_clk domain
  rst  in  1  synchronous active-high reset
  test_en  in  1  run enable; tie to init_calib_complete
  WR_BURST_ADRS_REQ  out  1  write burst request
  WR_BURST_ADRS  out  ADDR_WIDTH  write burst start byte address
  WR_BURST_LEN  out  10  write beats minus 0 (equals BURST_LEN)
  WR_READY  in  1  write request accepted when high with REQ
  WR_BURST_DATA_REQ  in  1  consumer takes WR_BURST_DATA this cycle
  WR_BURST_DATA  out  DATA_WIDTH  current write beat
  RD_BURST_ADRS_REQ  out  1  read burst request
  RD_BURST_ADRS  out  ADDR_WIDTH  read burst start byte address
  RD_BURST_LEN  out  10  read beats (equals BURST_LEN)
  RD_READY  in  1  read request accepted when high with REQ
  RD_BURST_DATA_VAL  in  1  read beat valid
  RD_BURST_DATA  in  DATA_WIDTH  read beat
  tg_compare_error  out  1  sticky mismatch flag
  error_count  out  16  saturating mismatched-beat count
  first_err_addr  out  ADDR_WIDTH  byte address of first mismatched beat
  pass_count  out  16  completed write+read passes, wraps
  busy  out  1  high in any state except IDLE

Function
REQ-007 FSM states IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA; one-hot or binary free.
REQ-008 IDLE -> WR_REQ when test_en=1; cur_addr loaded with BEGIN_ADDRESS.
REQ-009 WR_REQ: REQ high, ADRS=cur_addr held stable; REQ&READY same cycle -> WR_DATA, REQ low next cycle.
REQ-010 WR_DATA: WR_BURST_DATA combinationally equals pattern of current beat; beat counter advances on each WR_BURST_DATA_REQ; after beat BURST_LEN-1 taken, cur_addr += BURST_LEN*DATA_WIDTH/8.
REQ-011 After last write burst (burst start = END_ADDRESS+1-burst bytes) -> RD_REQ with cur_addr=BEGIN_ADDRESS; otherwise -> WR_REQ.
REQ-012 RD_REQ/RD_DATA mirror REQ-009/010 using RD_* ports; beats counted on RD_BURST_DATA_VAL.
REQ-013 After last read burst: pass_count +1, -> WR_REQ with BEGIN_ADDRESS if test_en=1, else IDLE.
REQ-014 Pattern: beat byte address A, 32-bit word W = A[31:0] + {16'h0, pass_count}; beat = W replicated DATA_WIDTH/32 times.
REQ-015 Compare registered one cycle after RD_BURST_DATA_VAL; mismatch sets tg_compare_error, increments error_count (saturate 16'hFFFF), captures first_err_addr only when error_count was 0.
REQ-016 test_en deassert mid-burst: current burst completes in full (all beats), then IDLE; no request dropped after acceptance.
REQ-017 RD_BURST_DATA_VAL or WR_BURST_DATA_REQ outside *_DATA states ignored; never advance counters.
REQ-018 Re-entry from IDLE restarts at BEGIN_ADDRESS; error state and pass_count retained.

Reset
REQ-019 rst=1 sampled on clk: state IDLE; all REQ outputs 0; ADRS outputs BEGIN_ADDRESS; LEN outputs BURST_LEN; tg_compare_error 0; error_count 0; first_err_addr 0; pass_count 0; busy 0; beat counter 0.
REQ-020 Reset mid-burst aborts immediately; no burst completion.

Structure
REQ-021 Shared package mem_test_pkg: state enum, BURST_BYTES constant, pattern function.
REQ-022 One sub-module mem_pattern_chk: registered compare plus error counters/capture.

Verification
REQ-023 BEGIN=0, END=0x1FFF, BURST_LEN=16, ideal responder: 32 write bursts at 0x000,0x100..0x1F00, then 32 reads; pass_count=1, tg_compare_error=0.
REQ-024 Responder corrupts bit 0 of read beat at address 0x0340 in pass 0 -> tg_compare_error=1, error_count=1, first_err_addr=0x0340.
REQ-025 WR_READY held low 50 cycles -> WR_BURST_ADRS_REQ and WR_BURST_ADRS=0x000 stable all 50 cycles; accepted once.
REQ-026 test_en dropped at beat 5 of write burst at 0x0200 -> remaining 11 beats taken, then IDLE, busy=0.
REQ-027 rst asserted during RD_DATA -> next cycle all outputs at REQ-019 values; restart writes from 0x000.
REQ-028 Pass 1 writes beat at 0x0010 as 32'h00000011 replicated.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory burst tester: FSM state encoding,
// burst sizing and the data pattern generator.
package mem_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4
    } state_e;

    // Burst size in bytes for the default configuration (16 beats x 128 bits).
    localparam int BURST_BYTES = 16 * 128 / 8;

    function automatic int burst_bytes(input int beats, input int data_width);
        return beats * data_width / 8;
    endfunction

    // The pass number is folded in so stale data from an earlier pass is caught.
    function automatic logic [31:0] pattern_word(input logic [31:0] addr,
                                                 input logic [15:0] pass);
        return addr + {16'h0000, pass};
    endfunction

endpackage

// File: rtl/mem_pattern_chk.sv
// Registered read-data compare with sticky error flag, saturating error
// counter and capture of the first failing beat address.
module mem_pattern_chk #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic [DATA_WIDTH-1:0] exp_data_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  err_o,
    output logic [15:0]           err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_addr_o
);

    logic                  err_q,        err_d;
    logic [15:0]           err_cnt_q,    err_cnt_d;
    logic [ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
    logic                  miss;

    assign miss = vld_i && (rd_data_i != exp_data_i);

    always_comb begin
        err_d        = err_q;
        err_cnt_d    = err_cnt_q;
        first_addr_d = first_addr_q;
        if (miss) begin
            err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            // Only the very first failure is recorded; later ones just count.
            if (err_cnt_q == 16'd0) begin
                first_addr_d = addr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q        <= 1'b0;
            err_cnt_q    <= 16'd0;
            first_addr_q <= '0;
        end else begin
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            first_addr_q <= first_addr_d;
        end
    end

    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;
    assign first_addr_o = first_addr_q;

endmodule

// File: rtl/mem_burst_tester.sv
// Memory burst traffic generator: writes a pass-dependent address pattern over
// [BEGIN_ADDRESS, END_ADDRESS] in bursts, reads it back and checks every beat.
module mem_burst_tester
    import mem_test_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 128,
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    BURST_LEN     = 16,
    parameter logic [ADDR_WIDTH-1:0] BEGIN_ADDRESS = 32'h00000000,
    parameter logic [ADDR_WIDTH-1:0] END_ADDRESS   = 32'h00ffffff
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  test_en,
    output logic                  WR_BURST_ADRS_REQ,
    output logic [ADDR_WIDTH-1:0] WR_BURST_ADRS,
    output logic [9:0]            WR_BURST_LEN,
    input  logic                  WR_READY,
    input  logic                  WR_BURST_DATA_REQ,
    output logic [DATA_WIDTH-1:0] WR_BURST_DATA,
    output logic                  RD_BURST_ADRS_REQ,
    output logic [ADDR_WIDTH-1:0] RD_BURST_ADRS,
    output logic [9:0]            RD_BURST_LEN,
    input  logic                  RD_READY,
    input  logic                  RD_BURST_DATA_VAL,
    input  logic [DATA_WIDTH-1:0] RD_BURST_DATA,
    output logic                  tg_compare_error,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [15:0]           pass_count,
    output logic                  busy
);

    localparam int                    BEAT_BYTES      = DATA_WIDTH / 8;
    localparam int                    BURST_SPAN      = burst_bytes(BURST_LEN, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN_A          = ADDR_WIDTH'(BURST_SPAN);
    localparam logic [ADDR_WIDTH-1:0] LAST_BURST_ADDR = END_ADDRESS - SPAN_A + ADDR_WIDTH'(1);
    localparam logic [8:0]            LAST_BEAT       = 9'(BURST_LEN - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [8:0]            beat_q, beat_d;
    logic [15:0]           pass_q, pass_d;

    logic                  last_beat;
    logic                  last_burst;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [31:0]           beat_word;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  chk_vld;

    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (cur_addr_q == LAST_BURST_ADDR);
    assign beat_addr  = cur_addr_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BEAT_BYTES);
    assign beat_word  = pattern_word(32'(beat_addr), pass_q);
    assign beat_data  = {(DATA_WIDTH/32){beat_word}};

    // Data-phase handshakes only count in their own state; strays elsewhere are ignored.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        beat_d     = beat_q;
        pass_d     = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (test_en) begin
                    state_d    = ST_WR_REQ;
                    cur_addr_d = BEGIN_ADDRESS;
                    beat_d     = '0;
                end
            end
            ST_WR_REQ: begin
                if (WR_READY) begin
                    state_d = ST_WR_DATA;
                    beat_d  = '0;
                end
            end
            ST_WR_DATA: begin
                if (WR_BURST_DATA_REQ) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            cur_addr_d = BEGIN_ADDRESS;
                            state_d    = ST_RD_REQ;
                        end else begin
                            cur_addr_d = cur_addr_q + SPAN_A;
                            state_d    = ST_WR_REQ;
                        end
                        if (!test_en) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            ST_RD_REQ: begin
                if (RD_READY) begin
                    state_d = ST_RD_DATA;
                    beat_d  = '0;
                end
            end
            ST_RD_DATA: begin
                if (RD_BURST_DATA_VAL) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            cur_addr_d = BEGIN_ADDRESS;
                            pass_d     = pass_q + 16'd1;
                            state_d    = ST_WR_REQ;
                        end else begin
                            cur_addr_d = cur_addr_q + SPAN_A;
                            state_d    = ST_RD_REQ;
                        end
                        if (!test_en) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= BEGIN_ADDRESS;
            beat_q     <= '0;
            pass_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            beat_q     <= beat_d;
            pass_q     <= pass_d;
        end
    end

    assign chk_vld = (state_q == ST_RD_DATA) && RD_BURST_DATA_VAL;

    mem_pattern_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_chk (
        .clk          (clk),
        .rst          (rst),
        .vld_i        (chk_vld),
        .rd_data_i    (RD_BURST_DATA),
        .exp_data_i   (beat_data),
        .addr_i       (beat_addr),
        .err_o        (tg_compare_error),
        .err_cnt_o    (error_count),
        .first_addr_o (first_err_addr)
    );

    assign WR_BURST_ADRS_REQ = (state_q == ST_WR_REQ);
    assign WR_BURST_ADRS     = cur_addr_q;
    assign WR_BURST_LEN      = 10'(BURST_LEN);
    assign WR_BURST_DATA     = beat_data;
    assign RD_BURST_ADRS_REQ = (state_q == ST_RD_REQ);
    assign RD_BURST_ADRS     = cur_addr_q;
    assign RD_BURST_LEN      = 10'(BURST_LEN);
    assign pass_count        = pass_q;
    assign busy              = (state_q != ST_IDLE);

endmodule
